// File: rtl/multicycle_alu.sv
// Registered execute-stage ALU: single-cycle logic/add/sub/slt plus iterative
// unsigned shift-add multiply and restoring divide, handshaked by start/busy/done.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [3:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALUOutHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_NOR = 4'd4,
    OP_SLT = 4'd5, OP_MULU = 4'd6, OP_DIVU = 4'd7, OP_ILL = 4'd8
  } op_t;

  function automatic op_t decode_op(input logic [1:0] aluop, input logic [3:0] func);
    op_t op;
    case (aluop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (func)
          4'b0000: op = OP_ADD;
          4'b0010: op = OP_SUB;
          4'b0100: op = OP_AND;
          4'b0101: op = OP_OR;
          4'b0111: op = OP_NOR;
          4'b1010: op = OP_SLT;
          default: op = OP_ILL;
        endcase
      end
      2'b11: begin
        case (func)
          4'b1000: op = OP_MULU;
          4'b1010: op = OP_DIVU;
          default: op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_hi_r, acc_hi_s, acc_lo_r, acc_lo_s, opb_r, opb_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] aluout_r, aluout_s, aluouthi_r, aluouthi_s;
  logic             zero_r, zero_s, ovf_r, ovf_s, divzero_r, divzero_s;
  logic             done_r, done_s, busy_r, busy_s;

  op_t              op_s;
  logic [WIDTH-1:0] sum_s, diff_s, res_s;
  logic             res_ovf_s;
  logic [WIDTH:0]   mul_sum_s, div_rem_s, div_diff_s;
  logic [WIDTH-1:0] mul_hi_s, mul_lo_s, div_hi_s, div_lo_s;

  assign op_s   = decode_op(ALUOp, FuncCode);
  assign sum_s  = A + B;
  assign diff_s = A - B;

  // Single-cycle result and signed-overflow flag for the decoded op
  always_comb begin
    res_s     = {WIDTH{1'b0}};
    res_ovf_s = 1'b0;
    case (op_s)
      OP_ADD: begin
        res_s     = sum_s;
        res_ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_s     = diff_s;
        res_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  res_s = A & B;
      OP_OR:   res_s = A | B;
      OP_NOR:  res_s = ~(A | B);
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add multiply step and one restoring divide step on the accumulators
  always_comb begin
    mul_sum_s  = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    mul_hi_s   = mul_sum_s[WIDTH:1];
    mul_lo_s   = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    div_rem_s  = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_diff_s = div_rem_s - {1'b0, opb_r};
    if (!div_diff_s[WIDTH]) begin
      div_hi_s = div_diff_s[WIDTH-1:0];
      div_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_s = div_rem_s[WIDTH-1:0];
      div_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and next-output logic; FIN is the done cycle and accepts like IDLE
  always_comb begin
    state_s    = state_r;
    acc_hi_s   = acc_hi_r;
    acc_lo_s   = acc_lo_r;
    opb_s      = opb_r;
    cnt_s      = cnt_r;
    aluout_s   = aluout_r;
    aluouthi_s = aluouthi_r;
    zero_s     = zero_r;
    ovf_s      = ovf_r;
    divzero_s  = divzero_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    case (state_r)
      IDLE, FIN: begin
        state_s = IDLE;
        if (start) begin
          if (op_s == OP_MULU) begin
            state_s  = MUL;
            busy_s   = 1'b1;
            acc_hi_s = {WIDTH{1'b0}};
            acc_lo_s = A;
            opb_s    = B;
            cnt_s    = {CW{1'b0}};
          end else if ((op_s == OP_DIVU) && (B != {WIDTH{1'b0}})) begin
            state_s  = DIV;
            busy_s   = 1'b1;
            acc_hi_s = {WIDTH{1'b0}};
            acc_lo_s = A;
            opb_s    = B;
            cnt_s    = {CW{1'b0}};
          end else if (op_s == OP_DIVU) begin
            aluout_s   = {WIDTH{1'b1}};
            aluouthi_s = A;
            zero_s     = 1'b0;
            ovf_s      = 1'b0;
            divzero_s  = 1'b1;
            done_s     = 1'b1;
          end else begin
            aluout_s   = res_s;
            aluouthi_s = {WIDTH{1'b0}};
            zero_s     = (res_s == {WIDTH{1'b0}});
            ovf_s      = res_ovf_s;
            divzero_s  = 1'b0;
            done_s     = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        acc_hi_s = mul_hi_s;
        acc_lo_s = mul_lo_s;
        if (cnt_r == LAST) begin
          state_s    = FIN;
          busy_s     = 1'b0;
          done_s     = 1'b1;
          aluout_s   = mul_lo_s;
          aluouthi_s = mul_hi_s;
          zero_s     = (mul_lo_s == {WIDTH{1'b0}});
          ovf_s      = 1'b0;
          divzero_s  = 1'b0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DIV: begin
        acc_hi_s = div_hi_s;
        acc_lo_s = div_lo_s;
        if (cnt_r == LAST) begin
          state_s    = FIN;
          busy_s     = 1'b0;
          done_s     = 1'b1;
          aluout_s   = div_lo_s;
          aluouthi_s = div_hi_s;
          zero_s     = (div_lo_s == {WIDTH{1'b0}});
          ovf_s      = 1'b0;
          divzero_s  = 1'b0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      acc_hi_r   <= {WIDTH{1'b0}};
      acc_lo_r   <= {WIDTH{1'b0}};
      opb_r      <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      aluout_r   <= {WIDTH{1'b0}};
      aluouthi_r <= {WIDTH{1'b0}};
      zero_r     <= 1'b1;
      ovf_r      <= 1'b0;
      divzero_r  <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      acc_hi_r   <= acc_hi_s;
      acc_lo_r   <= acc_lo_s;
      opb_r      <= opb_s;
      cnt_r      <= cnt_s;
      aluout_r   <= aluout_s;
      aluouthi_r <= aluouthi_s;
      zero_r     <= zero_s;
      ovf_r      <= ovf_s;
      divzero_r  <= divzero_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign ALUOut   = aluout_r;
  assign ALUOutHi = aluouthi_r;
  assign Zero     = zero_r;
  assign Overflow = ovf_r;
  assign DivZero  = divzero_r;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_multicycle_alu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    ALUOp;
  logic [3:0]    FuncCode;
  logic [W-1:0]  A, B;
  logic          busy, done, Zero, Overflow, DivZero;
  logic [W-1:0]  ALUOut, ALUOutHi;
  int            errors = 0;
  int            checks = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .FuncCode(FuncCode),
    .A(A), .B(B), .busy(busy), .done(done), .ALUOut(ALUOut), .ALUOutHi(ALUOutHi),
    .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  // Reference: results from the op's arithmetic meaning; lat = samples from accept edge to done
  task automatic model(input logic [1:0] op, input logic [3:0] fc, input logic [W-1:0] a, b,
                       output logic [W-1:0] r, hi, output logic ovf, dz, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b);
    r = '0; hi = '0; ovf = 1'b0; dz = 1'b0; lat = 1;
    if (op == 2'b00 || (op == 2'b10 && fc == 4'b0000)) begin
      s = sa + sb; r = a + b; ovf = (s != longint'($signed(r)));
    end else if (op == 2'b01 || (op == 2'b10 && fc == 4'b0010)) begin
      s = sa - sb; r = a - b; ovf = (s != longint'($signed(r)));
    end else if (op == 2'b10 && fc == 4'b0100) r = a & b;
    else if (op == 2'b10 && fc == 4'b0101) r = a | b;
    else if (op == 2'b10 && fc == 4'b0111) r = ~(a | b);
    else if (op == 2'b10 && fc == 4'b1010) r = (sa < sb) ? 32'd1 : 32'd0;
    else if (op == 2'b11 && fc == 4'b1000) begin
      p = 64'(a) * 64'(b); r = p[31:0]; hi = p[63:32]; lat = W + 1;
    end else if (op == 2'b11 && fc == 4'b1010) begin
      if (b == 0) begin r = 32'hFFFF_FFFF; hi = a; dz = 1'b1; end
      else begin r = a / b; hi = a % b; lat = W + 1; end
    end
  endtask

  // Issue one op and wait (bounded) for done; lat counts post-edge samples from accept
  task automatic run_op(input logic [1:0] op, input logic [3:0] fc, input logic [W-1:0] a, b,
                        output int lat);
    @(negedge clk);
    ALUOp = op; FuncCode = fc; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 3 * W) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat, seen;
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (ALUOut !== 32'h0) begin errors++; $display("FAIL rst_out: got %h expected 0", ALUOut); end
    checks++; if (ALUOutHi !== 32'h0) begin errors++; $display("FAIL rst_hi: got %h expected 0", ALUOutHi); end
    checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL rst_zero: got %b expected 1", Zero); end
    checks++; if ({Overflow, DivZero} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {Overflow, DivZero}); end
    @(negedge clk); reset = 1'b0;
    run_op(2'b00, 4'b0000, 32'd1, 32'd2, lat);
    checks++; if (ALUOut !== 32'd3) begin errors++; $display("FAIL pre_rst_add: got %h expected 3", ALUOut); end
    @(negedge clk);
    ALUOp = 2'b11; FuncCode = 4'b1000; A = 32'hFFFF; B = 32'hFFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (ALUOut !== 32'h0) begin errors++; $display("FAIL abort_out: got %h expected 0", ALUOut); end
    checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL abort_zero: got %b expected 1", Zero); end
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b expected 0", busy); end
  endtask

  task automatic test_add_sub_slt();
    int lat;
    run_op(2'b00, 4'b0000, 32'h7FFF_FFFF, 32'd1, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL add_lat: got %0d expected 1", lat); end
    checks++; if (ALUOut !== 32'h8000_0000) begin errors++; $display("FAIL add_out: got %h expected 80000000", ALUOut); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL add_ovf: got %b expected 1", Overflow); end
    checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b expected 0", Zero); end
    run_op(2'b10, 4'b1010, 32'hFFFF_FFFF, 32'd1, lat);
    checks++; if (ALUOut !== 32'd1) begin errors++; $display("FAIL slt_out: got %h expected 1", ALUOut); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL slt_ovf: got %b expected 0", Overflow); end
    run_op(2'b01, 4'b0000, 32'd5, 32'd5, lat);
    checks++; if (ALUOut !== 32'd0) begin errors++; $display("FAIL sub_out: got %h expected 0", ALUOut); end
    checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL sub_zero: got %b expected 1", Zero); end
    run_op(2'b01, 4'b0000, 32'h8000_0000, 32'd1, lat);
    checks++; if (ALUOut !== 32'h7FFF_FFFF || Overflow !== 1'b1) begin
      errors++; $display("FAIL sub_ovf: got %h/%b expected 7fffffff/1", ALUOut, Overflow);
    end
  endtask

  task automatic test_mul();
    int lat, busy_cnt;
    @(negedge clk);
    ALUOp = 2'b11; FuncCode = 4'b1000; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 3 * W) begin
      if (lat == 5) begin start = 1'b1; ALUOp = 2'b00; A = 32'd1; B = 32'd1; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) busy_cnt++;
    end
    start = 1'b0;
    checks++; if (lat != W + 1) begin errors++; $display("FAIL mul_lat: got %0d expected %0d", lat, W + 1); end
    checks++; if (busy_cnt != W) begin errors++; $display("FAIL mul_busy: got %0d expected %0d", busy_cnt, W); end
    checks++; if (ALUOutHi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_hi: got %h expected fffffffe", ALUOutHi); end
    checks++; if (ALUOut !== 32'h0000_0001) begin errors++; $display("FAIL mul_lo: got %h expected 00000001", ALUOut); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_no_queue: got %b expected 0", done); end
    checks++; if (ALUOut !== 32'h0000_0001) begin errors++; $display("FAIL mul_hold: got %h expected 00000001", ALUOut); end
  endtask

  task automatic test_div();
    int lat;
    run_op(2'b11, 4'b1010, 32'd100, 32'd7, lat);
    checks++; if (lat != W + 1) begin errors++; $display("FAIL div_lat: got %0d expected %0d", lat, W + 1); end
    checks++; if (ALUOut !== 32'd14) begin errors++; $display("FAIL div_quo: got %0d expected 14", ALUOut); end
    checks++; if (ALUOutHi !== 32'd2) begin errors++; $display("FAIL div_rem: got %0d expected 2", ALUOutHi); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL div_dz: got %b expected 0", DivZero); end
    run_op(2'b11, 4'b1010, 32'd100, 32'd0, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_lat: got %0d expected 1", lat); end
    checks++; if (ALUOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_out: got %h expected ffffffff", ALUOut); end
    checks++; if (ALUOutHi !== 32'd100) begin errors++; $display("FAIL dz_hi: got %0d expected 100", ALUOutHi); end
    checks++; if (DivZero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", DivZero); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, exp;
    logic [3:0] fcs [3];
    a = 32'hF0F0_1234; b = 32'h0FF0_00FF;
    fcs[0] = 4'b0100; fcs[1] = 4'b0101; fcs[2] = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ALUOp = 2'b10; FuncCode = fcs[i]; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      exp = (i == 0) ? (a & b) : (i == 1) ? (a | b) : ~(a | b);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done%0d: got %b expected 1", i, done); end
      checks++; if (ALUOut !== exp) begin errors++; $display("FAIL b2b_out%0d: got %h expected %h", i, ALUOut, exp); end
      checks++; if ({ALUOutHi, DivZero} !== {32'h0, 1'b0}) begin
        errors++; $display("FAIL b2b_hi_dz%0d: got %h/%b expected 0/0", i, ALUOutHi, DivZero);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", done); end
    checks++; if (ALUOut !== 32'h000F_ED00) begin errors++; $display("FAIL b2b_hold: got %h expected 000fed00", ALUOut); end
  endtask

  task automatic test_illegal();
    int lat;
    run_op(2'b10, 4'b1111, 32'h1234_5678, 32'h0000_0042, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL ill_lat: got %0d expected 1", lat); end
    checks++; if (ALUOut !== 32'h0 || Zero !== 1'b1) begin
      errors++; $display("FAIL ill_out: got %h/%b expected 0/1", ALUOut, Zero);
    end
    run_op(2'b00, 4'b0000, 32'd9, 32'd9, lat);
    run_op(2'b11, 4'b0000, 32'd9, 32'd9, lat);
    checks++; if (lat != 1 || ALUOut !== 32'h0 || Zero !== 1'b1) begin
      errors++; $display("FAIL ill_ext: got lat %0d out %h zero %b expected 1/0/1", lat, ALUOut, Zero);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [3:0] fc;
    logic [W-1:0] a, b, er, eh;
    logic eo, ed;
    int el, lat;
    logic [3:0] r_fcs [8];
    r_fcs[0] = 4'b0000; r_fcs[1] = 4'b0010; r_fcs[2] = 4'b0100; r_fcs[3] = 4'b0101;
    r_fcs[4] = 4'b0111; r_fcs[5] = 4'b1010; r_fcs[6] = 4'b1000; r_fcs[7] = 4'b0011;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      fc = r_fcs[$urandom_range(0, 7)];
      a = $urandom;
      b = $urandom;
      if (op == 2'b11 && $urandom_range(0, 2) != 0) fc = ($urandom_range(0, 1) != 0) ? 4'b1000 : 4'b1010;
      if (op == 2'b11 && fc == 4'b1010) begin
        case ($urandom_range(0, 3))
          0: b = 32'd0;
          1: b = 32'($urandom_range(1, 255));
          default: b = $urandom;
        endcase
      end
      model(op, fc, a, b, er, eh, eo, ed, el);
      run_op(op, fc, a, b, lat);
      checks++; if (lat != el) begin errors++; $display("FAIL rnd%0d_lat: op %b fc %b got %0d expected %0d", i, op, fc, lat, el); end
      checks++; if (ALUOut !== er) begin errors++; $display("FAIL rnd%0d_out: op %b fc %b got %h expected %h", i, op, fc, ALUOut, er); end
      checks++; if (ALUOutHi !== eh) begin errors++; $display("FAIL rnd%0d_hi: got %h expected %h", i, ALUOutHi, eh); end
      checks++; if (Zero !== (er == 0)) begin errors++; $display("FAIL rnd%0d_zero: got %b expected %b", i, Zero, (er == 0)); end
      checks++; if (Overflow !== eo) begin errors++; $display("FAIL rnd%0d_ovf: got %b expected %b", i, Overflow, eo); end
      checks++; if (DivZero !== ed) begin errors++; $display("FAIL rnd%0d_dz: got %b expected %b", i, DivZero, ed); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ALUOp = 2'b00; FuncCode = 4'b0000; A = '0; B = '0;
    test_reset();
    test_add_sub_slt();
    test_mul();
    test_div();
    test_back_to_back();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered successor to the combinational single-cycle ALU/ALU-control pair.
- Decodes ALUOp/FuncCode internally and executes logic and add/sub/slt ops in one cycle.
- Adds iterative unsigned multiply (shift-add) and divide (restoring), taking WIDTH cycles each.
- Sits in the multicycle datapath execute stage; the controller uses start/busy/done to stall.

Parameters:
- WIDTH, 32, operand and result width (≥4).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- ALUOp  input  2  00 add, 01 sub, 10 R-type (use FuncCode), 11 extended mul/div
- FuncCode  input  4  low bits of MIPS funct
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- busy  output  1  operation in progress; start ignored
- done  output  1  one-cycle pulse, results valid
- ALUOut  output  WIDTH  result / product low / quotient
- ALUOutHi  output  WIDTH  product high / remainder; 0 for single-cycle ops
- Zero  output  1  ALUOut == 0
- Overflow  output  1  signed overflow on add/sub, else 0
- DivZero  output  1  divide by zero occurred

Behaviour:
- Reset: synchronous on the clk edge with reset=1; busy=0, done=0, ALUOut=0, ALUOutHi=0, Zero=1, Overflow=0, DivZero=0, FSM=IDLE. Reset mid-operation aborts with no done pulse.
- Decode at accept:
  - ALUOp=00 → ADD; ALUOp=01 → SUB.
  - ALUOp=10 FuncCode: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0111 NOR, 1010 SLT (signed).
  - ALUOp=11 FuncCode: 1000 MULU, 1010 DIVU.
  - Any other code is ILLEGAL: result 0, single-cycle.
- Accept: start=1 and busy=0 at edge N; A, B, and op are latched. Inputs after N are don't-care.
- FSM states IDLE, MUL, DIV, FIN.
  - IDLE + accept of a single-cycle op → results registered at edge N; done=1 during cycle N+1 (latency 1); busy stays 0. Back-to-back starts every cycle are legal.
  - IDLE + MULU → MUL, busy=1. One shift-add step per cycle for WIDTH cycles, then FIN.
  - IDLE + DIVU, B≠0 → DIV, busy=1. One restoring step per cycle for WIDTH cycles, then FIN.
  - FIN: registers results, busy=0, done=1 next cycle. Mul/div done is high in cycle N+WIDTH+1.
  - DIVU with B=0 → no iteration; ALUOut=all ones, ALUOutHi=A, DivZero=1, done at N+1 as for single-cycle ops.
- Arithmetic:
  - ADD/SUB results are modulo 2^WIDTH.
  - Overflow = (sign A == sign B') and (sign result ≠ sign A), where B' = B for add and ~B for sub.
  - SLT result is 1 or 0, zero-extended.
  - MULU: {ALUOutHi, ALUOut} = 2·WIDTH-bit unsigned product.
  - DIVU: ALUOut = quotient, ALUOutHi = remainder.
- Outputs hold their value until the next completion; Overflow and DivZero are updated on every completion.
- start while busy=1 is ignored and never queued.
- done and start asserted in the same cycle with busy=0 → new op accepted; outputs change only at its completion.

Test Plan:
- Reset: assert reset 2 cycles mid-MULU → busy=0, done never pulses, ALUOut=0, Zero=1.
- ALUOp=00, A=0x7FFFFFFF, B=1 → done at N+1, ALUOut=0x80000000, Overflow=1, Zero=0.
- ALUOp=10, FuncCode=1010, A=0xFFFFFFFF, B=1 → ALUOut=1 (signed −1<1). ALUOp=01, A=B=5 → ALUOut=0, Zero=1.
- ALUOp=11, FuncCode=1000, A=0xFFFFFFFF, B=0xFFFFFFFF → busy for 32 cycles, done at N+33, ALUOutHi=0xFFFFFFFE, ALUOut=0x00000001. A start pulse mid-op is ignored.
- ALUOp=11, FuncCode=1010, A=100, B=7 → done at N+33, ALUOut=14, ALUOutHi=2. Repeat with B=0 → done at N+1, ALUOut=0xFFFFFFFF, ALUOutHi=100, DivZero=1.
- Back-to-back single-cycle ops (AND, OR, NOR) on consecutive cycles → three consecutive done pulses with matching results. Illegal code ALUOp=10, FuncCode=1111 → ALUOut=0, Zero=1.
